// File: rtl/lacc_fmap_responder.sv
// Responder end of the lacc data channel: walks a raster grid, reads feature-map words and returns them in request order.
// Define LACC_PAD_EN to honour cfg_pad (zero border pixels answered without a memory access).
module lacc_fmap_responder #(
   parameter int ADDR_W      = 32,
   parameter int DIM_W       = 8,
   parameter int OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [DIM_W-1:0]  cfg_width_m1,
   input  logic [DIM_W-1:0]  cfg_height_m1,
   input  logic [1:0]        cfg_pad,
   output logic              busy,
   output logic              done,
   input  logic              lacc_data_valid,
   output logic              lacc_data_ready,
   output logic              lacc_drsp_valid,
   output logic [31:0]       lacc_drsp_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int PW = $clog2(OUTSTANDING);
   localparam int GW = DIM_W + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] stride_q, row_base, col_off, col_start, start_col, start_row_off, addr_sum;
   logic [DIM_W-1:0]  width_m1_q, height_m1_q;
   logic [GW-1:0]     x, y, wl_m1, hl_m1;
   logic [CW-1:0]     inflight;
   logic [1:0]        pad, start_pad;
   logic              run, credit, is_pad, accept, last;

   logic [31:0]       ret_mem [OUTSTANDING];
   logic [PW-1:0]     ret_rd, ret_wr;
   logic [CW-1:0]     ret_cnt;
   logic              rvalid_in, ret_empty, ret_avail, ret_push, ret_pop;
   logic [31:0]       ret_head;
   logic              head_pad, fire;

`ifdef LACC_PAD_EN
   logic [1:0]        pad_q;
   logic              tag_mem [OUTSTANDING];
   logic [PW-1:0]     tag_rd, tag_wr;
   logic [CW-1:0]     tag_cnt;
   logic              tag_empty, tag_push, tag_pop, head_valid;

   assign pad           = pad_q;
   assign start_pad     = cfg_pad;
   assign wl_m1         = GW'(width_m1_q) + GW'({pad, 1'b0});
   assign hl_m1         = GW'(height_m1_q) + GW'({pad, 1'b0});
   assign is_pad        = (x < GW'(pad)) || (x > GW'(width_m1_q) + GW'(pad)) ||
                          (y < GW'(pad)) || (y > GW'(height_m1_q) + GW'(pad));
   assign start_row_off = (cfg_pad[0] ? cfg_stride : '0) +
                          (cfg_pad[1] ? {cfg_stride[ADDR_W-2:0], 1'b0} : '0);

   // An empty tag FIFO is bypassed so a pad pixel answers in the cycle after its accept.
   assign tag_empty  = (tag_cnt == '0);
   assign head_valid = !tag_empty || accept;
   assign head_pad   = tag_empty ? is_pad : tag_mem[tag_rd];
   assign fire       = head_valid && (head_pad || ret_avail);
   assign tag_push   = accept && !(fire && tag_empty);
   assign tag_pop    = fire && !tag_empty;

   always_ff @(posedge clk) begin
      if (rst)
         pad_q <= 2'b00;
      else if (state == S_IDLE && start)
         pad_q <= cfg_pad;
   end

   always_ff @(posedge clk) begin
      if (tag_push)
         tag_mem[tag_wr] <= is_pad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_rd  <= '0;
         tag_wr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (tag_push)
            tag_wr <= tag_wr + PW'(1);
         if (tag_pop)
            tag_rd <= tag_rd + PW'(1);
         if (tag_push && !tag_pop)
            tag_cnt <= tag_cnt + CW'(1);
         else if (tag_pop && !tag_push)
            tag_cnt <= tag_cnt - CW'(1);
      end
   end
`else
   logic unused_pad;

   assign unused_pad    = ^cfg_pad;
   assign pad           = 2'b00;
   assign start_pad     = 2'b00;
   assign wl_m1         = GW'(width_m1_q);
   assign hl_m1         = GW'(height_m1_q);
   assign is_pad        = 1'b0;
   assign start_row_off = '0;
   assign head_pad      = 1'b0;
   assign fire          = ret_avail;
`endif

   assign run             = (state == S_RUN);
   assign busy            = (state != S_IDLE);
   assign credit          = (inflight < CW'(OUTSTANDING));
   assign lacc_data_ready = run && credit && (is_pad || mem_gnt);
   assign mem_req         = run && credit && lacc_data_valid && !is_pad;
   assign accept          = lacc_data_valid && lacc_data_ready;
   assign last            = (x == wl_m1) && (y == hl_m1);
   assign col_start       = ADDR_W'(0) - ADDR_W'({pad, 2'b00});
   assign start_col       = ADDR_W'(0) - ADDR_W'({start_pad, 2'b00});
   assign addr_sum        = row_base + col_off;
   assign mem_addr        = {addr_sum[ADDR_W-1:2], 2'b00};

   // An empty return FIFO is bypassed so read data can answer in the cycle after mem_rvalid.
   assign rvalid_in = mem_rvalid && (state != S_IDLE);
   assign ret_empty = (ret_cnt == '0);
   assign ret_avail = !ret_empty || rvalid_in;
   assign ret_head  = ret_empty ? mem_rdata : ret_mem[ret_rd];
   assign ret_pop   = fire && !head_pad && !ret_empty;
   assign ret_push  = rvalid_in && !(fire && !head_pad && ret_empty);

   // Frame control: the cursor and the address accumulators only move on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         done        <= 1'b0;
         x           <= '0;
         y           <= '0;
         row_base    <= '0;
         col_off     <= '0;
         stride_q    <= '0;
         width_m1_q  <= '0;
         height_m1_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  stride_q    <= cfg_stride;
                  width_m1_q  <= cfg_width_m1;
                  height_m1_q <= cfg_height_m1;
                  row_base    <= cfg_base - start_row_off;
                  col_off     <= start_col;
                  x           <= '0;
                  y           <= '0;
                  state       <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (last) begin
                     state <= S_DRAIN;
                  end else if (x == wl_m1) begin
                     x        <= '0;
                     y        <= y + GW'(1);
                     row_base <= row_base + stride_q;
                     col_off  <= col_start;
                  end else begin
                     x       <= x + GW'(1);
                     col_off <= col_off + ADDR_W'(4);
                  end
               end
            end
            S_DRAIN: begin
               if (inflight == '0) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (accept && !fire)
         inflight <= inflight + CW'(1);
      else if (fire && !accept)
         inflight <= inflight - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (ret_push)
         ret_mem[ret_wr] <= mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ret_rd  <= '0;
         ret_wr  <= '0;
         ret_cnt <= '0;
      end else begin
         if (ret_push)
            ret_wr <= ret_wr + PW'(1);
         if (ret_pop)
            ret_rd <= ret_rd + PW'(1);
         if (ret_push && !ret_pop)
            ret_cnt <= ret_cnt + CW'(1);
         else if (ret_pop && !ret_push)
            ret_cnt <= ret_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lacc_drsp_valid <= 1'b0;
         lacc_drsp_rdata <= '0;
      end else begin
         lacc_drsp_valid <= fire;
         if (fire)
            lacc_drsp_rdata <= head_pad ? 32'h0 : ret_head;
      end
   end

endmodule

// File: tb/tb_lacc_fmap_responder.sv
// Self-checking bench for lacc_fmap_responder: raster-order reference model, latency-programmable memory, directed frames.
// The padding frame is exercised only when LACC_PAD_EN is defined.
module tb_lacc_fmap_responder;

   localparam int ADDR_W      = 32;
   localparam int DIM_W       = 8;
   localparam int OUTSTANDING = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] cfg_base = '0;
   logic [ADDR_W-1:0] cfg_stride = '0;
   logic [DIM_W-1:0]  cfg_width_m1 = '0;
   logic [DIM_W-1:0]  cfg_height_m1 = '0;
   logic [1:0]        cfg_pad = '0;
   logic              busy, done;
   logic              lacc_data_valid = 1'b0;
   logic              lacc_data_ready;
   logic              lacc_drsp_valid;
   logic [31:0]       lacc_drsp_rdata;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [31:0]       mem_rdata = '0;

   lacc_fmap_responder #(
      .ADDR_W(ADDR_W), .DIM_W(DIM_W), .OUTSTANDING(OUTSTANDING)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_base(cfg_base), .cfg_stride(cfg_stride),
      .cfg_width_m1(cfg_width_m1), .cfg_height_m1(cfg_height_m1), .cfg_pad(cfg_pad),
      .busy(busy), .done(done),
      .lacc_data_valid(lacc_data_valid), .lacc_data_ready(lacc_data_ready),
      .lacc_drsp_valid(lacc_drsp_valid), .lacc_drsp_rdata(lacc_drsp_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
   } pend_t;

   int          n_checks = 0;
   int          n_fails = 0;
   int          cycle = 0;
   int          mem_lat = 1;
   bit          valid_en = 1'b0;
   bit          gnt_en = 1'b1;
   bit          pad_frame = 1'b0;
   bit          first_rsp_seen = 1'b0;
   int          acc_cnt, rsp_cnt, req_cnt, done_cnt, mdl_inflight;
   int          first_acc_cyc, last_acc_cyc, acc_at_first_rsp;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_rsp[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_rsp[$];
   pend_t       pend[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Memory image: a small window holds 0xA..0xD, everything else is a function of the address.
   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a >= 32'h2000 && a < 32'h2010)
         return 32'hA + ((a - 32'h2000) >> 2);
      return a ^ 32'hDEAD_0000;
   endfunction

   // Reference frame: every grid pixel in raster order, address by direct multiplication.
   task automatic build_frame(input logic [31:0] base, input logic [31:0] stride,
                              input int wm1, input int hm1, input int pad);
      int p, wl, hl;
      logic [31:0] a;
`ifdef LACC_PAD_EN
      p = pad;
`else
      p = 0;
      if (pad != 0)
         $display("[TB] padding not compiled in, pad=%0d ignored", pad);
`endif
      wl = wm1 + 1 + 2 * p;
      hl = hm1 + 1 + 2 * p;
      exp_rsp.delete();
      exp_addr.delete();
      for (int yy = 0; yy < hl; yy++) begin
         for (int xx = 0; xx < wl; xx++) begin
            if (xx < p || xx >= p + wm1 + 1 || yy < p || yy >= p + hm1 + 1) begin
               exp_rsp.push_back(32'h0);
            end else begin
               a = base + 32'(yy - p) * stride + 32'((xx - p) * 4);
               exp_addr.push_back(a);
               exp_rsp.push_back(data_of(a));
            end
         end
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride,
                                input int wm1, input int hm1, input int pad);
      build_frame(base, stride, wm1, hm1, pad);
      obs_addr.delete();
      obs_rsp.delete();
      acc_cnt = 0; rsp_cnt = 0; req_cnt = 0; done_cnt = 0; mdl_inflight = 0;
      first_rsp_seen = 1'b0; acc_at_first_rsp = -1;
      cfg_base = base;
      cfg_stride = stride;
      cfg_width_m1 = DIM_W'(wm1);
      cfg_height_m1 = DIM_W'(hm1);
      cfg_pad = 2'(pad);
      valid_en = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      cfg_base = 32'hFFFF_0000;
      cfg_stride = 32'h0000_0ABC;
      cfg_width_m1 = 8'd77;
      cfg_height_m1 = 8'd55;
      cfg_pad = 2'd3;
   endtask

   task automatic finish_frame(input int limit);
      int k;
      k = 0;
      while (done_cnt == 0 && k < limit) begin
         tick;
         k++;
      end
      checkOutput("frame_done_seen", 32'(done_cnt != 0), 1);
      repeat (3) tick;
      valid_en = 1'b0;
      checkOutput("done_once", done_cnt, 1);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("responses_left", exp_rsp.size(), 0);
      checkOutput("requests_left", exp_addr.size(), 0);
   endtask

   task automatic wait_accepts(input int n);
      int k;
      k = 0;
      while (acc_cnt < n && k < 200) begin
         tick;
         k++;
      end
      checkOutput("accepts_reached", 32'(acc_cnt >= n), 1);
   endtask

   // Compare process and memory model: sample registered outputs, drive returns, then observe handshakes.
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (!rst) begin
            if (lacc_drsp_valid) begin
               obs_rsp.push_back(lacc_drsp_rdata);
               if (!first_rsp_seen) begin
                  first_rsp_seen = 1'b1;
                  acc_at_first_rsp = acc_cnt;
               end
               rsp_cnt++;
               mdl_inflight--;
               if (exp_rsp.size() == 0)
                  checkOutput("unexpected_rsp", 1, 0);
               else
                  checkOutput("rsp_data", lacc_drsp_rdata, exp_rsp.pop_front());
            end
            if (done)
               done_cnt++;
         end
         if (pend.size() > 0 && pend[0].due <= cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata = pend[0].data;
            void'(pend.pop_front());
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
         end
         lacc_data_valid = valid_en;
         mem_gnt = gnt_en;
         #1;
         if (!rst) begin
            if (mem_req) begin
               if (exp_addr.size() == 0)
                  checkOutput("unexpected_req", 1, 0);
               else
                  checkOutput("mem_addr", mem_addr, exp_addr[0]);
               if (mem_gnt) begin
                  obs_addr.push_back(mem_addr);
                  if (exp_addr.size() > 0)
                     void'(exp_addr.pop_front());
                  pend.push_back('{data_of(mem_addr), cycle + mem_lat});
                  req_cnt++;
               end
            end
            if (!mem_gnt && busy && !pad_frame)
               checkOutput("ready_when_stalled", lacc_data_ready, 0);
            if (mdl_inflight >= OUTSTANDING)
               checkOutput("ready_without_credit", lacc_data_ready, 0);
            if (lacc_data_valid && lacc_data_ready) begin
               if (acc_cnt == 0)
                  first_acc_cyc = cycle;
               last_acc_cyc = cycle;
               acc_cnt++;
               mdl_inflight++;
            end
            if (busy)
               checkOutput("inflight_bound", 32'(mdl_inflight <= OUTSTANDING), 1);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int held;
      rst = 1'b1;
      repeat (3) tick;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_ready", lacc_data_ready, 0);
      checkOutput("reset_drsp_valid", lacc_drsp_valid, 0);
      checkOutput("reset_drsp_rdata", lacc_drsp_rdata, 0);
      checkOutput("reset_mem_req", mem_req, 0);
      rst = 1'b0;
      tick;

      $display("[TB] basic 4x2 frame, latency 1");
      mem_lat = 1;
      applyStimulus(32'h1000, 32'h40, 3, 1, 0);
      finish_frame(200);
      checkOutput("basic_req_cnt", req_cnt, 8);
      checkOutput("basic_rsp_cnt", rsp_cnt, 8);
      checkOutput("basic_addr0", obs_addr[0], 32'h1000);
      checkOutput("basic_addr3", obs_addr[3], 32'h100C);
      checkOutput("basic_addr4", obs_addr[4], 32'h1040);
      checkOutput("basic_addr7", obs_addr[7], 32'h104C);
      checkOutput("basic_rsp0", obs_rsp[0], 32'hDEAD_1000);
      checkOutput("basic_rsp7", obs_rsp[7], 32'hDEAD_104C);
      checkOutput("basic_back_to_back", last_acc_cyc - first_acc_cyc, 7);

      $display("[TB] credit limit, latency 10");
      mem_lat = 10;
      applyStimulus(32'h3000, 32'h100, 3, 1, 0);
      finish_frame(400);
      checkOutput("credit_accepts_before_rsp", acc_at_first_rsp, OUTSTANDING);
      checkOutput("credit_rsp_cnt", rsp_cnt, 8);

      $display("[TB] grant stall mid-row");
      mem_lat = 1;
      applyStimulus(32'h4000, 32'h20, 3, 1, 0);
      wait_accepts(2);
      gnt_en = 1'b0;
      tick;
      held = acc_cnt;
      repeat (4) tick;
      checkOutput("stall_no_accept", acc_cnt, held);
      gnt_en = 1'b1;
      finish_frame(200);
      checkOutput("stall_req_cnt", req_cnt, 8);
      checkOutput("stall_rsp_cnt", rsp_cnt, 8);

`ifdef LACC_PAD_EN
      $display("[TB] padded 2x2 frame, pad 1");
      pad_frame = 1'b1;
      applyStimulus(32'h2000, 32'h8, 1, 1, 1);
      finish_frame(300);
      pad_frame = 1'b0;
      checkOutput("pad_rsp_cnt", rsp_cnt, 16);
      checkOutput("pad_req_cnt", req_cnt, 4);
      checkOutput("pad_rsp0", obs_rsp[0], 32'h0);
      checkOutput("pad_rsp4", obs_rsp[4], 32'h0);
      checkOutput("pad_rsp5", obs_rsp[5], 32'hA);
      checkOutput("pad_rsp6", obs_rsp[6], 32'hB);
      checkOutput("pad_rsp7", obs_rsp[7], 32'h0);
      checkOutput("pad_rsp9", obs_rsp[9], 32'hC);
      checkOutput("pad_rsp10", obs_rsp[10], 32'hD);
      checkOutput("pad_rsp15", obs_rsp[15], 32'h0);
`endif

      $display("[TB] reset mid-frame with requests outstanding");
      mem_lat = 2;
      applyStimulus(32'h5000, 32'h40, 3, 1, 0);
      wait_accepts(3);
      valid_en = 1'b0;
      tick;
      rst = 1'b1;
      exp_rsp.delete();
      exp_addr.delete();
      mdl_inflight = 0;
      tick;
      rst = 1'b0;
      repeat (8) tick;
      checkOutput("rst_no_done", done_cnt, 0);
      checkOutput("rst_idle", busy, 0);
      checkOutput("rst_rsp_before_reset", rsp_cnt, 1);
      mem_lat = 1;
      applyStimulus(32'h6000, 32'h40, 3, 1, 0);
      finish_frame(200);
      checkOutput("rst_clean_rsp_cnt", rsp_cnt, 8);

      $display("[TB] start while busy is ignored");
      mem_lat = 3;
      applyStimulus(32'h7000, 32'h80, 3, 1, 0);
      repeat (2) tick;
      cfg_base = 32'h9000;
      cfg_stride = 32'h10;
      cfg_width_m1 = 8'd1;
      cfg_height_m1 = 8'd0;
      start = 1'b1;
      tick;
      start = 1'b0;
      finish_frame(300);
      checkOutput("restart_rsp_cnt", rsp_cnt, 8);
      checkOutput("restart_addr4", obs_addr[4], 32'h7080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
